// File: rtl/score_keeper.sv
// Score, high score and lives bookkeeping for one game.
// Simultaneous kills queue in a pending mask and score one per cycle.
module score_keeper #(
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 120
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  NPC_Collision,
    input  logic        Ship_Collision,
    input  logic [2:0]  Curr_Level,
    input  logic        NewGame,
    output logic [15:0] Score,
    output logic [15:0] HiScore,
    output logic [2:0]  Lives,
    output logic        Lives_Zero,
    output logic        Game_Over_Pulse,
    output logic        Busy
);

    localparam logic [2:0] LIVES_L = 3'(LIVES);
    localparam logic [6:0] INV_L   = 7'(INVULN_FRAMES);

    logic [15:0] r_score;
    logic [15:0] r_hi;
    logic [2:0]  r_lives;
    logic [6:0]  r_inv;
    logic [9:0]  r_pend;
    logic [9:0]  r_npc_prev;
    logic        r_ship_prev;
    logic        r_go;
    logic [2:0]  r_fs;

    logic [9:0]  w_npc_rise;
    logic [9:0]  w_serve;
    logic [3:0]  w_pts;
    logic        w_ship_rise;
    logic        w_hit;
    logic        w_tick;
    logic [4:0]  w_t1, w_t2, w_t3;
    logic [4:0]  w_m1, w_m2, w_m3;
    logic        w_c1, w_c2, w_c3;
    logic [3:0]  w_d1, w_d2, w_d3;
    logic [15:0] w_sum;

    assign w_npc_rise  = NPC_Collision & ~r_npc_prev;
    // two's-complement trick isolates the lowest pending bit
    assign w_serve     = r_pend & (~r_pend + 10'd1);
    assign w_pts       = {1'b0, Curr_Level} + 4'd1;
    assign w_ship_rise = Ship_Collision & ~r_ship_prev;
    assign w_hit       = w_ship_rise && (r_inv == 7'd0) && (r_lives != 3'd0);
    assign w_tick      = r_fs[1] & ~r_fs[2];

    always_comb begin
        w_t1 = {1'b0, r_score[7:4]} + {1'b0, w_pts};
        w_m1 = w_t1 - 5'd10;
        w_c1 = (w_t1 > 5'd9);
        w_d1 = w_c1 ? w_m1[3:0] : w_t1[3:0];
        w_t2 = {1'b0, r_score[11:8]} + {4'd0, w_c1};
        w_m2 = w_t2 - 5'd10;
        w_c2 = (w_t2 > 5'd9);
        w_d2 = w_c2 ? w_m2[3:0] : w_t2[3:0];
        w_t3 = {1'b0, r_score[15:12]} + {4'd0, w_c2};
        w_m3 = w_t3 - 5'd10;
        w_c3 = (w_t3 > 5'd9);
        w_d3 = w_c3 ? w_m3[3:0] : w_t3[3:0];
        w_sum = w_c3 ? 16'h9999 : {w_d3, w_d2, w_d1, r_score[3:0]};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_score     <= 16'd0;
            r_hi        <= 16'd0;
            r_lives     <= LIVES_L;
            r_inv       <= 7'd0;
            r_pend      <= 10'd0;
            r_npc_prev  <= 10'd0;
            r_ship_prev <= 1'b0;
            r_go        <= 1'b0;
            r_fs        <= 3'd0;
        end else begin
            r_fs <= {r_fs[1:0], frame_clk};
            if (NewGame) begin
                r_hi        <= (r_score > r_hi) ? r_score : r_hi;
                r_score     <= 16'd0;
                r_lives     <= LIVES_L;
                r_inv       <= 7'd0;
                r_pend      <= 10'd0;
                r_npc_prev  <= 10'd0;
                r_ship_prev <= 1'b0;
                r_go        <= 1'b0;
            end else begin
                r_npc_prev  <= NPC_Collision;
                r_ship_prev <= Ship_Collision;
                r_pend      <= (r_pend & ~w_serve) | w_npc_rise;
                if (|r_pend) begin
                    r_score <= w_sum;
                end
                r_go <= w_hit && (r_lives == 3'd1);
                if (w_hit) begin
                    r_lives <= r_lives - 3'd1;
                    r_inv   <= INV_L;
                end else if (w_tick && (r_inv != 7'd0)) begin
                    r_inv <= r_inv - 7'd1;
                end
            end
        end
    end

    assign Score           = r_score;
    assign HiScore         = r_hi;
    assign Lives           = r_lives;
    assign Lives_Zero      = (r_lives == 3'd0);
    assign Game_Over_Pulse = r_go;
    assign Busy            = |r_pend;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: decimal-integer reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_score_keeper;

    localparam int LIVES  = 3;
    localparam int INVULN = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic [9:0]  NPC_Collision = '0;
    logic        Ship_Collision = 1'b0;
    logic [2:0]  Curr_Level = '0;
    logic        NewGame = 1'b0;
    logic [15:0] Score;
    logic [15:0] HiScore;
    logic [2:0]  Lives;
    logic        Lives_Zero;
    logic        Game_Over_Pulse;
    logic        Busy;

    int n_checks = 0;
    int n_err = 0;
    bit armed = 0;

    score_keeper #(.LIVES(LIVES), .INVULN_FRAMES(INVULN)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .NPC_Collision(NPC_Collision),
        .Ship_Collision(Ship_Collision),
        .Curr_Level(Curr_Level),
        .NewGame(NewGame),
        .Score(Score),
        .HiScore(HiScore),
        .Lives(Lives),
        .Lives_Zero(Lives_Zero),
        .Game_Over_Pulse(Game_Over_Pulse),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // reference model: plain integers, decimal arithmetic
    int         m_score, m_hi, m_lives, m_inv;
    bit [9:0]   m_pend, m_nprev;
    bit         m_sprev, m_go;
    bit         fc_past [0:2];

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_score = 0; m_hi = 0; m_lives = LIVES; m_inv = 0;
            m_pend = '0; m_nprev = '0; m_sprev = 0; m_go = 0;
            for (int i = 0; i < 3; i++) fc_past[i] = 0;
        end else begin
            bit tick;
            int low;
            // frame tick: frame_clk seen high two samples ago, low three ago
            tick = fc_past[1] && !fc_past[2];
            fc_past[2] = fc_past[1];
            fc_past[1] = fc_past[0];
            fc_past[0] = frame_clk;
            if (NewGame) begin
                if (m_score > m_hi) m_hi = m_score;
                m_score = 0; m_lives = LIVES; m_inv = 0;
                m_pend = '0; m_nprev = '0; m_sprev = 0; m_go = 0;
            end else begin
                low = -1;
                for (int i = 9; i >= 0; i--) if (m_pend[i]) low = i;
                if (low >= 0) begin
                    m_score = m_score + 10 * (int'(Curr_Level) + 1);
                    if (m_score > 9999) m_score = 9999;
                    m_pend[low] = 0;
                end
                for (int i = 0; i < 10; i++)
                    if (NPC_Collision[i] && !m_nprev[i]) m_pend[i] = 1;
                m_nprev = NPC_Collision;
                m_go = 0;
                if (Ship_Collision && !m_sprev && m_inv == 0 && m_lives > 0) begin
                    if (m_lives == 1) m_go = 1;
                    m_lives = m_lives - 1;
                    m_inv = INVULN;
                end else if (tick && m_inv > 0) begin
                    m_inv = m_inv - 1;
                end
                m_sprev = Ship_Collision;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (armed) begin
            chk("model_score", Score, to_bcd(m_score));
            chk("model_hiscore", HiScore, to_bcd(m_hi));
            chk("model_lives", {13'd0, Lives}, 16'(m_lives));
            chk("model_lives_zero", {15'd0, Lives_Zero}, {15'd0, m_lives == 0});
            chk("model_gameover", {15'd0, Game_Over_Pulse}, {15'd0, m_go});
            chk("model_busy", {15'd0, Busy}, {15'd0, m_pend != 0});
        end
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic kill_mask(input logic [9:0] mask, input logic [2:0] lvl);
        NPC_Collision = mask;
        Curr_Level = lvl;
        step();
        NPC_Collision = '0;
        repeat ($countones(mask)) step();
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        repeat (4) step();
        frame_clk = 1'b0;
        repeat (4) step();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
    endtask

    initial begin
        int fcnt;
        #1 Reset = 1'b1;
        armed = 1;
        repeat (2) step();
        Reset = 1'b0;
        step();
        chk("reset_score", Score, 16'h0000);
        chk("reset_hiscore", HiScore, 16'h0000);
        chk("reset_lives", {13'd0, Lives}, 16'd3);
        chk("reset_busy", {15'd0, Busy}, 16'd0);

        // single kill at level 0
        Curr_Level = 3'd0;
        NPC_Collision = 10'h008;
        step();
        chk("single_busy", {15'd0, Busy}, 16'd1);
        chk("single_pre", Score, 16'h0000);
        NPC_Collision = '0;
        step();
        chk("single_score", Score, 16'h0010);
        chk("single_idle", {15'd0, Busy}, 16'd0);

        // three simultaneous kills at level 2, BCD carry into hundreds
        Curr_Level = 3'd2;
        NPC_Collision = 10'h221;
        step();
        NPC_Collision = '0;
        step();
        chk("multi_1", Score, 16'h0040);
        step();
        chk("multi_2", Score, 16'h0070);
        chk("multi_busy", {15'd0, Busy}, 16'd1);
        step();
        chk("multi_3", Score, 16'h0100);
        chk("multi_idle", {15'd0, Busy}, 16'd0);

        // saturation: 124 kills at 80 plus one at 70 give 9990
        do_reset();
        repeat (12) kill_mask(10'h3FF, 3'd7);
        kill_mask(10'h00F, 3'd7);
        kill_mask(10'h001, 3'd6);
        chk("sat_9990", Score, 16'h9990);
        kill_mask(10'h002, 3'd7);
        chk("sat_9999", Score, 16'h9999);
        kill_mask(10'h004, 3'd7);
        chk("sat_hold", Score, 16'h9999);

        // lives and invulnerability
        Ship_Collision = 1'b1;
        step();
        chk("hit_1", {13'd0, Lives}, 16'd2);
        Ship_Collision = 1'b0;
        step();
        Ship_Collision = 1'b1;
        step();
        chk("hit_immune", {13'd0, Lives}, 16'd2);
        Ship_Collision = 1'b0;
        frame_pulse();
        frame_pulse();
        Ship_Collision = 1'b1;
        step();
        chk("hit_2", {13'd0, Lives}, 16'd1);
        chk("hit_2_nogo", {15'd0, Game_Over_Pulse}, 16'd0);
        Ship_Collision = 1'b0;
        frame_pulse();
        frame_pulse();
        Ship_Collision = 1'b1;
        step();
        chk("hit_3", {13'd0, Lives}, 16'd0);
        chk("hit_3_zero", {15'd0, Lives_Zero}, 16'd1);
        chk("gameover_on", {15'd0, Game_Over_Pulse}, 16'd1);
        Ship_Collision = 1'b0;
        step();
        chk("gameover_off", {15'd0, Game_Over_Pulse}, 16'd0);
        frame_pulse();
        frame_pulse();
        Ship_Collision = 1'b1;
        step();
        chk("dead_lives", {13'd0, Lives}, 16'd0);
        chk("dead_nogo", {15'd0, Game_Over_Pulse}, 16'd0);
        Ship_Collision = 1'b0;
        step();

        // new game with a coincident kill
        do_reset();
        kill_mask(10'h01F, 3'd7);
        kill_mask(10'h001, 3'd4);
        chk("pre_newgame", Score, 16'h0450);
        NewGame = 1'b1;
        NPC_Collision = 10'h004;
        step();
        NewGame = 1'b0;
        NPC_Collision = '0;
        chk("ng_hiscore", HiScore, 16'h0450);
        chk("ng_score", Score, 16'h0000);
        chk("ng_lives", {13'd0, Lives}, 16'd3);
        step();
        chk("ng_discard", Score, 16'h0000);
        chk("ng_idle", {15'd0, Busy}, 16'd0);

        // asynchronous reset in the middle of serialisation
        NPC_Collision = 10'h3FF;
        step();
        NPC_Collision = '0;
        step();
        Reset = 1'b1;
        #1;
        chk("rst_score", Score, 16'h0000);
        chk("rst_hiscore", HiScore, 16'h0000);
        chk("rst_lives", {13'd0, Lives}, 16'd3);
        chk("rst_busy", {15'd0, Busy}, 16'd0);
        step();
        Reset = 1'b0;
        step();

        // randomized traffic against the model
        fcnt = 0;
        for (int c = 0; c < 4000; c++) begin
            NPC_Collision = 10'($urandom & $urandom & $urandom);
            Ship_Collision = ($urandom_range(0, 5) == 0);
            Curr_Level = 3'($urandom_range(0, 7));
            NewGame = ($urandom_range(0, 150) == 0);
            Reset = ($urandom_range(0, 800) == 0);
            if (fcnt == 0) begin
                frame_clk = ~frame_clk;
                fcnt = $urandom_range(2, 9);
            end else begin
                fcnt--;
            end
            step();
        end
        Reset = 1'b0;
        NewGame = 1'b0;
        step();
        armed = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
